// File: rtl/row_unload_mdl.sv
// Matrix-to-row unloader: captures a packed matrix, streams it out row 0 first on valid/ready.
// Latency: first row valid 1 cycle after an accepted load; one row per cycle at full throughput.
// Backpressure: out_row/rowIndex/dendFlag/out_parity hold while out_ready=0; load ignored while busy.
// Optional per-element even parity on out_parity enabled by macro ROW_UNLOAD_PARITY_EN.
module row_unload_mdl #(
  parameter int DATA_SIZE   = 16,
  parameter int COLUMN_SIZE = 16,
  parameter int ROW_SIZE    = 16
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       load,
  input  logic [$clog2(ROW_SIZE+1)-1:0]              in_rowCount,
  input  logic [DATA_SIZE*COLUMN_SIZE*ROW_SIZE-1:0]  in_matrix,
  input  logic                                       out_ready,
  output logic                                       out_valid,
  output logic [DATA_SIZE*COLUMN_SIZE-1:0]           out_row,
  output logic [$clog2(ROW_SIZE)-1:0]                rowIndex,
  output logic                                       dendFlag,
  output logic [COLUMN_SIZE-1:0]                     out_parity,
  output logic                                       busy,
  output logic                                       doneFlag
);

  localparam int ROW_W = DATA_SIZE * COLUMN_SIZE;
  localparam int MAT_W = ROW_W * ROW_SIZE;
  localparam int CW    = $clog2(ROW_SIZE + 1);
  localparam int IW    = $clog2(ROW_SIZE);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t            r_state;
  logic [MAT_W-1:0]  r_shadow;
  logic [CW-1:0]     r_count;
  logic [IW-1:0]     r_idx;
  logic [ROW_W-1:0]  r_row;
  logic              r_valid;
  logic              r_busy;
  logic              r_dend;
  logic              r_done;

  logic [CW-1:0]     w_clamped;
  logic [IW-1:0]     w_next_idx;
  logic [ROW_W-1:0]  w_next_row;
  logic [ROW_W-1:0]  w_first_row;
  logic              w_next_last;
  logic              w_take_load;
  logic              w_hs;
  logic              w_finish;
  logic              w_advance;

  // Requests beyond the matrix height are clamped to the full matrix.
  assign w_clamped   = (in_rowCount > CW'(ROW_SIZE)) ? CW'(ROW_SIZE) : in_rowCount;
  assign w_next_idx  = r_idx + IW'(1);
  assign w_next_row  = r_shadow[w_next_idx*ROW_W +: ROW_W];
  // Row 0 is registered straight from the input at capture so it is ready the next cycle.
  assign w_first_row = in_matrix[ROW_W-1:0];
  // The row about to be presented is the last one when idx+2 equals the count.
  assign w_next_last = ((CW'(r_idx) + CW'(2)) == r_count);

  assign w_take_load = (r_state == S_IDLE) && load && (in_rowCount != '0);
  // out_valid is always high in SEND, so a handshake is just out_ready there.
  assign w_hs        = (r_state == S_SEND) && out_ready;
  assign w_finish    = w_hs && r_dend;
  assign w_advance   = w_hs && !r_dend;

  // Transfer FSM: capture on load, step one row per handshake, pulse done after the last.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_count  <= '0;
      r_idx    <= '0;
      r_row    <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_dend   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take_load) begin
            r_shadow <= in_matrix;
            r_count  <= w_clamped;
            r_idx    <= '0;
            r_row    <= w_first_row;
            r_dend   <= (w_clamped == CW'(1));
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_finish) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_dend  <= 1'b0;
            r_idx   <= '0;
            r_row   <= '0;
            r_done  <= 1'b1;
          end else if (w_advance) begin
            r_idx  <= w_next_idx;
            r_row  <= w_next_row;
            r_dend <= w_next_last;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ROW_UNLOAD_PARITY_EN
  logic [COLUMN_SIZE-1:0] r_parity;

  function automatic logic [COLUMN_SIZE-1:0] f_parity(input logic [ROW_W-1:0] row);
    logic [COLUMN_SIZE-1:0] p;
    p = '0;
    for (int c = 0; c < COLUMN_SIZE; c++) begin
      p[c] = ^row[c*DATA_SIZE +: DATA_SIZE];
    end
    return p;
  endfunction

  // Parity follows out_row on the same edge, computed from the row being loaded.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_parity <= '0;
    end else if (w_take_load) begin
      r_parity <= f_parity(w_first_row);
    end else if (w_advance) begin
      r_parity <= f_parity(w_next_row);
    end else if (w_finish) begin
      r_parity <= '0;
    end
  end

  assign out_parity = r_parity;
`else
  assign out_parity = '0;
`endif

  assign out_valid = r_valid;
  assign out_row   = r_row;
  assign rowIndex  = r_idx;
  assign dendFlag  = r_dend;
  assign busy      = r_busy;
  assign doneFlag  = r_done;

endmodule

// File: tb/tb_row_unload_mdl.sv
// Bench for row_unload_mdl: directed scenarios plus random traffic against a transfer-level model.
module tb_row_unload_mdl;

  localparam int DS    = 16;
  localparam int CS    = 16;
  localparam int RS    = 16;
  localparam int ROW_W = DS * CS;
  localparam int MAT_W = ROW_W * RS;
  localparam int CW    = $clog2(RS + 1);
  localparam int IW    = $clog2(RS);

  logic              clock;
  logic              reset;
  logic              load;
  logic [CW-1:0]     in_rowCount;
  logic [MAT_W-1:0]  in_matrix;
  logic              out_ready;
  logic              out_valid;
  logic [ROW_W-1:0]  out_row;
  logic [IW-1:0]     rowIndex;
  logic              dendFlag;
  logic [CS-1:0]     out_parity;
  logic              busy;
  logic              doneFlag;

  row_unload_mdl #(.DATA_SIZE(DS), .COLUMN_SIZE(CS), .ROW_SIZE(RS)) dut (
    .clock(clock), .reset(reset), .load(load), .in_rowCount(in_rowCount),
    .in_matrix(in_matrix), .out_ready(out_ready), .out_valid(out_valid),
    .out_row(out_row), .rowIndex(rowIndex), .dendFlag(dendFlag),
    .out_parity(out_parity), .busy(busy), .doneFlag(doneFlag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the matrix being sent, how many rows, which row is on the bus.
  bit               m_active = 1'b0;
  logic [MAT_W-1:0] m_mat    = '0;
  int               m_cnt    = 0;
  int               m_pos    = 0;
  bit               m_done   = 1'b0;

  int acc_q[$];

  task automatic chk(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [MAT_W-1:0] rnd_mat();
    logic [MAT_W-1:0] m;
    for (int i = 0; i < MAT_W / 32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [MAT_W-1:0] pattern_mat();
    logic [MAT_W-1:0] m;
    for (int r = 0; r < RS; r++)
      for (int c = 0; c < CS; c++) m[(r*CS + c)*DS +: DS] = DS'(r*16 + c);
    return m;
  endfunction

  function automatic logic [CS-1:0] exp_par(input logic [ROW_W-1:0] row);
    logic [CS-1:0] p;
    p = '0;
`ifdef ROW_UNLOAD_PARITY_EN
    for (int c = 0; c < CS; c++) p[c] = $countones(row[c*DS +: DS]) % 2 == 1;
`endif
    return p;
  endfunction

  function automatic void model_update(input bit ld, input int rc, input bit rdy, input bit rst,
                                       input logic [MAT_W-1:0] mat);
    bit nd;
    nd = 1'b0;
    if (rst) begin
      m_active = 1'b0; m_pos = 0; m_cnt = 0;
    end else if (m_active) begin
      if (rdy) begin
        if (m_pos == m_cnt - 1) begin m_active = 1'b0; m_pos = 0; nd = 1'b1; end
        else m_pos++;
      end
    end else if (ld && rc > 0) begin
      m_mat = mat; m_cnt = (rc > RS) ? RS : rc; m_pos = 0; m_active = 1'b1;
    end
    m_done = nd;
  endfunction

  task automatic check_all();
    logic [ROW_W-1:0] er;
    er = m_mat[m_pos*ROW_W +: ROW_W];
    chk("out_valid", out_valid, m_active);
    chk("busy", busy, m_active);
    chk("doneFlag", doneFlag, m_done);
    chk("dendFlag", dendFlag, m_active && (m_pos == m_cnt - 1));
    chk("out_parity", out_parity, m_active ? exp_par(er) : '0);
    if (m_active) begin
      chk("out_row", out_row, er);
      chk("rowIndex", rowIndex, m_pos);
    end
  endtask

  // One clock: drive inputs, advance model on the edge, compare on the falling edge.
  task automatic step(input bit ld, input int rc, input bit rdy, input bit rst,
                      input logic [MAT_W-1:0] mat);
    logic             pv;
    logic [ROW_W-1:0] prow;
    logic [IW-1:0]    pidx;
    pv = out_valid; prow = out_row; pidx = rowIndex;
    load = ld; in_rowCount = CW'(rc); out_ready = rdy; reset = rst; in_matrix = mat;
    if (out_valid && rdy && !rst) acc_q.push_back(int'(rowIndex));
    @(posedge clock);
    model_update(ld, rc, rdy, rst, mat);
    @(negedge clock);
    check_all();
    if (pv && !rdy && !rst && out_valid) begin
      chk("hold_row", out_row, prow);
      chk("hold_idx", rowIndex, pidx);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (doneFlag) break;
      step(0, 0, 1, 0, rnd_mat());
    end
    chk("done_seen", doneFlag, 1'b1);
  endtask

  initial begin
    logic [MAT_W-1:0] pm, ma, mb, mc, md, me, mp;
    int nb, nd;
    int bp[7] = '{1, 0, 0, 1, 0, 1, 1};
    reset = 1'b1; load = 1'b0; in_rowCount = '0; in_matrix = '0; out_ready = 1'b0;

    step(0, 0, 0, 1, '0);
    step(0, 0, 1, 1, '0);
    chk("rst_row", out_row, '0);
    chk("rst_idx", rowIndex, '0);

    // Full throughput, 16 rows
    pm = pattern_mat();
    step(1, 16, 1, 0, pm);
    chk("ft_first_valid", out_valid, 1'b1);
    chk("ft_row0", out_row, pm[ROW_W-1:0]);
    nb = busy ? 1 : 0; nd = 0;
    for (int i = 0; i < 18; i++) begin
      step(0, 0, 1, 0, rnd_mat());
      if (busy) nb++;
      if (doneFlag) nd++;
      if (dendFlag) chk("ft_dend_idx", rowIndex, 15);
    end
    chk("ft_busy_cycles", nb, 16);
    chk("ft_done_pulses", nd, 1);

    // Backpressure, 4 rows
    acc_q.delete();
    step(1, 4, 0, 0, rnd_mat());
    foreach (bp[i]) step(0, 0, bp[i][0], 0, rnd_mat());
    step(0, 0, 1, 0, rnd_mat());
    step(0, 0, 1, 0, rnd_mat());
    chk("bp_accepted", acc_q.size(), 4);
    for (int i = 0; i < acc_q.size() && i < 4; i++) chk("bp_order", acc_q[i], i);

    // Zero-row load ignored
    step(1, 0, 1, 0, rnd_mat());
    chk("rc0_busy", busy, 1'b0);
    step(0, 0, 1, 0, rnd_mat());
    chk("rc0_done", doneFlag, 1'b0);

    // Single row
    step(1, 1, 0, 0, rnd_mat());
    chk("rc1_dend", dendFlag, 1'b1);
    step(0, 0, 1, 0, rnd_mat());
    chk("rc1_done", doneFlag, 1'b1);

    // Over-long request clamps to the full matrix
    acc_q.delete();
    step(1, 20, 1, 0, rnd_mat());
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, rnd_mat());
    chk("clamp_rows", acc_q.size(), 16);

    // Load mid-transfer ignored, then back-to-back load on the done cycle
    ma = rnd_mat(); mb = rnd_mat(); mc = rnd_mat();
    step(1, 6, 1, 0, ma);
    step(0, 0, 1, 0, ma);
    step(1, 6, 1, 0, mb);
    chk("ign_row", out_row, ma[2*ROW_W +: ROW_W]);
    wait_done();
    step(1, 3, 1, 0, mc);
    chk("b2b_valid", out_valid, 1'b1);
    chk("b2b_row0", out_row, mc[ROW_W-1:0]);
    chk("b2b_idx0", rowIndex, 0);
    wait_done();

    // Reset after row 2 is accepted
    md = rnd_mat(); me = rnd_mat();
    step(1, 8, 1, 0, md);
    step(0, 0, 1, 0, md);
    step(0, 0, 1, 0, md);
    step(0, 0, 1, 0, md);
    chk("pre_rst_idx", rowIndex, 3);
    step(0, 0, 1, 1, md);
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_row", out_row, '0);
    chk("mrst_done", doneFlag, 1'b0);
    step(0, 0, 1, 0, rnd_mat());
    chk("mrst_nodone", doneFlag, 1'b0);
    step(1, 5, 0, 0, me);
    chk("mrst_restart_row", out_row, me[ROW_W-1:0]);
    chk("mrst_restart_idx", rowIndex, 0);
    wait_done();

    // Parity
    mp = '0; mp[15:0] = 16'h0001; mp[31:16] = 16'h0003;
    step(1, 2, 0, 0, mp);
`ifdef ROW_UNLOAD_PARITY_EN
    chk("par_row0", out_parity, 16'h0001);
`else
    chk("par_row0", out_parity, 16'h0000);
`endif
    wait_done();

    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 20), $urandom_range(0, 2) != 0,
           $urandom_range(0, 80) == 0, rnd_mat());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
